// File: rtl/core_arb_pkg.sv
// core_arb_pkg: shared types and helpers for the core memory arbiter.
// Provides the index-width function and the owner record (valid + core index)
// used for lock ownership and pending read returns.
package core_arb_pkg;
    // Wide enough for the largest supported core count (16).
    localparam int OWNER_IDX_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [OWNER_IDX_W-1:0] idx;
    } owner_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of one requester.
// Ports: i_req (request vector), i_ptr (highest-priority index),
//        o_gnt (one-hot winner), o_idx (winner index), o_any (a winner exists).
module rr_priority_picker
    import core_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [idx_w(N)-1:0]  i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [idx_w(N)-1:0]  o_idx,
    output logic                 o_any
);
    localparam int IW = idx_w(N);

    // Each requester's distance from the pointer (wrapping); the smallest wins.
    always_comb begin
        int best;
        int off;
        best  = N;
        off   = 0;
        o_idx = '0;
        for (int c = 0; c < N; c++) begin
            off = (c >= int'(i_ptr)) ? c - int'(i_ptr) : c + N - int'(i_ptr);
            if (i_req[c] && off < best) begin
                best  = off;
                o_idx = IW'(c);
            end
        end
        o_any = best < N;
        o_gnt = o_any ? N'(1) << o_idx : '0;
    end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one single-port data memory among cores.
// Ports: clk/rst (async active-high); core_req/core_wr_en/core_lock/core_addr/core_wdata
//        per-core requests; core_gnt one-hot accept; core_rvalid/core_rdata read return
//        one cycle after a granted read; mem_addr/mem_wr_en/mem_wdata/mem_rdata memory port.
module core_mem_arbiter
    import core_arb_pkg::*;
#(
    parameter int CORE_COUNT          = 4,
    parameter int REG_WIDTH           = 12,
    parameter int DATA_MEM_ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CORE_COUNT-1:0]               core_req,
    input  logic [CORE_COUNT-1:0]               core_wr_en,
    input  logic [CORE_COUNT-1:0]               core_lock,
    input  logic [DATA_MEM_ADDR_WIDTH*CORE_COUNT-1:0] core_addr,
    input  logic [REG_WIDTH*CORE_COUNT-1:0]     core_wdata,
    output logic [CORE_COUNT-1:0]               core_gnt,
    output logic [CORE_COUNT-1:0]               core_rvalid,
    output logic [REG_WIDTH-1:0]                core_rdata,
    output logic [DATA_MEM_ADDR_WIDTH-1:0]      mem_addr,
    output logic                                mem_wr_en,
    output logic [REG_WIDTH-1:0]                mem_wdata,
    input  logic [REG_WIDTH-1:0]                mem_rdata
);
    localparam int IW = idx_w(CORE_COUNT);
    localparam int AW = DATA_MEM_ADDR_WIDTH;
    localparam int DW = REG_WIDTH;

    logic [IW-1:0]         r_rr_ptr;
    owner_t                r_lock_owner;
    owner_t                r_rd_owner;
    logic [CORE_COUNT-1:0] w_rr_gnt;
    logic [CORE_COUNT-1:0] w_lock_vec;
    logic [IW-1:0]         w_rr_idx;
    logic [IW-1:0]         w_win_idx;
    logic                  w_rr_any;
    logic                  w_lock_hit;
    logic                  w_any;

    rr_priority_picker #(.N(CORE_COUNT)) u_picker (
        .i_req (core_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // Decode both owner records into one-hot vectors.
    always_comb begin
        w_lock_vec  = '0;
        core_rvalid = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            w_lock_vec[i]  = r_lock_owner.valid && r_lock_owner.idx == OWNER_IDX_W'(i);
            core_rvalid[i] = r_rd_owner.valid && r_rd_owner.idx == OWNER_IDX_W'(i);
        end
    end

    // A lock only overrides round-robin while its owner is still requesting.
    assign w_lock_hit = |(w_lock_vec & core_req);
    assign w_any      = !rst && (w_lock_hit || w_rr_any);
    assign w_win_idx  = w_lock_hit ? IW'(r_lock_owner.idx) : w_rr_idx;

    assign core_gnt   = !w_any ? '0 : w_lock_hit ? w_lock_vec : w_rr_gnt;
    assign mem_addr   = w_any ? core_addr[w_win_idx*AW +: AW] : '0;
    assign mem_wdata  = w_any ? core_wdata[w_win_idx*DW +: DW] : '0;
    assign mem_wr_en  = w_any && core_wr_en[w_win_idx];
    assign core_rdata = r_rd_owner.valid ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_rd_owner   <= '0;
        end else begin
            if (w_any && !w_lock_hit)
                r_rr_ptr <= (int'(w_win_idx) == CORE_COUNT - 1) ? '0 : w_win_idx + 1'b1;
            r_lock_owner.valid <= w_any && core_lock[w_win_idx];
            r_lock_owner.idx   <= OWNER_IDX_W'(w_win_idx);
            r_rd_owner.valid   <= w_any && !core_wr_en[w_win_idx];
            r_rd_owner.idx     <= OWNER_IDX_W'(w_win_idx);
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed and randomized checks of core_mem_arbiter against a reference model.
module tb_core_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 12;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    core_req = '0, core_wr_en = '0, core_lock = '0;
    logic [AW*N-1:0] core_addr = '0;
    logic [DW*N-1:0] core_wdata = '0;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en;

    logic            pl_en = 1'b0;
    logic [AW-1:0]   pl_addr = '0;
    logic [DW-1:0]   pl_data = '0;
    logic [DW-1:0]   ram [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0]   mm  [0:(1<<AW)-1] = '{default: '0};

    int errors = 0;
    int checks = 0;
    int m_ptr, m_lock, m_rd, win;
    bit lockwin;
    logic [DW-1:0] m_rd_data;
    logic [N-1:0]  exp_gnt, exp_rvalid;
    logic [DW-1:0] exp_rdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    logic          exp_wr, exp_lock;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    core_mem_arbiter #(.CORE_COUNT(N), .REG_WIDTH(DW), .DATA_MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .core_req(core_req), .core_wr_en(core_wr_en),
        .core_lock(core_lock), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic set_core(input int i, input bit r, input bit w, input bit l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req[i] = r; core_wr_en[i] = w; core_lock[i] = l;
        core_addr[i*AW +: AW] = a; core_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        core_req = '0; core_wr_en = '0; core_lock = '0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_rd = -1;
    endtask

    // Expected outputs for the current cycle, taken at the falling edge.
    task automatic eval();
        @(negedge clk);
        win = -1; lockwin = 0;
        if (!rst) begin
            if (m_lock >= 0 && core_req[m_lock]) begin win = m_lock; lockwin = 1; end
            else for (int o = 0; o < N; o++) if (win < 0 && core_req[(m_ptr + o) % N]) win = (m_ptr + o) % N;
        end
        exp_gnt = '0; exp_wr = 0; exp_lock = 0; exp_addr = '0; exp_wdata = '0;
        if (win >= 0) begin
            exp_gnt = N'(1 << win);
            exp_wr = core_wr_en[win];
            exp_lock = core_lock[win];
            exp_addr = core_addr[win*AW +: AW];
            exp_wdata = core_wdata[win*DW +: DW];
        end
        exp_rvalid = (!rst && m_rd >= 0) ? N'(1 << m_rd) : '0;
        exp_rdata  = (!rst && m_rd >= 0) ? m_rd_data : '0;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        if (win >= 0) begin
            if (!lockwin) m_ptr = (win + 1) % N;
            m_lock = exp_lock ? win : -1;
            if (exp_wr) begin mm[exp_addr] = exp_wdata; m_rd = -1; end
            else begin m_rd = win; m_rd_data = mm[exp_addr]; end
        end else begin
            m_lock = -1; m_rd = -1;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d; mm[a] = d;
        eval(); commit();
        pl_en = 0;
    endtask

    task automatic apply_reset();
        clear_all(); rst = 1;
        @(posedge clk); #1;
        rst = 0; model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_core(i, 1, 1, 1, 12'h5A5, 12'h3C3);
        eval();
        checks++; if (core_gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b want 0", core_gnt); end
        checks++; if (core_rvalid !== '0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", core_rvalid); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", mem_wr_en); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        checks++; if (core_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", core_rdata); end
        clear_all();
        @(posedge clk); #1;
        rst = 0; model_reset();
        preload(12'h010, 12'hABC);
        preload(12'h020, 12'h111);
        preload(12'h021, 12'h222);
    endtask

    task automatic test_single_read();
        set_core(2, 1, 0, 0, 12'h010, 12'h000);
        eval();
        checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL sr_gnt: got %b want 0100", core_gnt); end
        checks++; if (mem_addr !== 12'h010) begin errors++; $display("FAIL sr_addr: got %h want 010", mem_addr); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL sr_wr_en: got %b want 0", mem_wr_en); end
        commit(); clear_all();
        eval();
        checks++; if (core_rvalid !== 4'b0100) begin errors++; $display("FAIL sr_rvalid: got %b want 0100", core_rvalid); end
        checks++; if (core_rdata !== 12'hABC) begin errors++; $display("FAIL sr_rdata: got %h want abc", core_rdata); end
        checks++; if (core_gnt !== '0) begin errors++; $display("FAIL sr_gnt_idle: got %b want 0", core_gnt); end
        commit();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < N; i++) set_core(i, 1, 1, 0, AW'(i), DW'(12'h100 + i));
        for (int c = 0; c < 5; c++) begin
            eval();
            checks++; if (core_gnt !== N'(1 << (c % N))) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, core_gnt, N'(1 << (c % N))); end
            checks++; if (mem_addr !== AW'(c % N)) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", c, mem_addr, AW'(c % N)); end
            checks++; if (mem_wdata !== DW'(12'h100 + c % N)) begin errors++; $display("FAIL rr_wdata[%0d]: got %h want %h", c, mem_wdata, DW'(12'h100 + c % N)); end
            checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en[%0d]: got %b want 1", c, mem_wr_en); end
            checks++; if (core_rvalid !== '0) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want 0", c, core_rvalid); end
            commit();
        end
        clear_all();
    endtask

    task automatic test_lock();
        set_core(0, 1, 1, 0, 12'h030, 12'h0A0);
        set_core(1, 1, 1, 1, 12'h031, 12'h0A1);
        set_core(3, 1, 1, 0, 12'h033, 12'h0A3);
        for (int c = 0; c < 3; c++) begin
            eval();
            checks++; if (core_gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want 0010", c, core_gnt); end
            commit();
        end
        core_req[1] = 0;
        eval();
        checks++; if (core_gnt !== 4'b1000) begin errors++; $display("FAIL lock_release_gnt: got %b want 1000", core_gnt); end
        commit();
        core_req[3] = 0;
        eval();
        checks++; if (core_gnt !== 4'b0001) begin errors++; $display("FAIL lock_after_gnt: got %b want 0001", core_gnt); end
        commit();
        clear_all();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_core(0, 1, 0, 0, 12'h020, 12'h000);
        set_core(1, 1, 0, 0, 12'h021, 12'h000);
        eval();
        checks++; if (core_gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0: got %b want 0001", core_gnt); end
        commit();
        core_req[0] = 0;
        eval();
        checks++; if (core_gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt1: got %b want 0010", core_gnt); end
        checks++; if (core_rvalid !== 4'b0001) begin errors++; $display("FAIL b2b_rvalid0: got %b want 0001", core_rvalid); end
        checks++; if (core_rdata !== 12'h111) begin errors++; $display("FAIL b2b_rdata0: got %h want 111", core_rdata); end
        commit(); clear_all();
        eval();
        checks++; if (core_rvalid !== 4'b0010) begin errors++; $display("FAIL b2b_rvalid1: got %b want 0010", core_rvalid); end
        checks++; if (core_rdata !== 12'h222) begin errors++; $display("FAIL b2b_rdata1: got %h want 222", core_rdata); end
        commit();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_core(2, 1, 0, 0, 12'h010, 12'h000);
        eval();
        checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL mr_gnt: got %b want 0100", core_gnt); end
        commit(); clear_all();
        checks++; if (core_rvalid !== 4'b0100) begin errors++; $display("FAIL mr_pending: got %b want 0100", core_rvalid); end
        #1 rst = 1;
        #1;
        checks++; if (core_rvalid !== '0) begin errors++; $display("FAIL mr_async_rvalid: got %b want 0", core_rvalid); end
        checks++; if (core_rdata !== '0) begin errors++; $display("FAIL mr_async_rdata: got %h want 0", core_rdata); end
        eval();
        checks++; if (core_rvalid !== exp_rvalid) begin errors++; $display("FAIL mr_rvalid: got %b want %b", core_rvalid, exp_rvalid); end
        @(posedge clk); #1;
        rst = 0; model_reset();
        set_core(3, 1, 0, 0, 12'h021, 12'h000);
        set_core(0, 1, 0, 0, 12'h020, 12'h000);
        eval();
        checks++; if (core_gnt !== 4'b0001) begin errors++; $display("FAIL mr_release_gnt: got %b want 0001", core_gnt); end
        checks++; if (core_rvalid !== '0) begin errors++; $display("FAIL mr_release_rvalid: got %b want 0", core_rvalid); end
        commit();
        core_req[0] = 0;
        eval();
        checks++; if (core_gnt !== 4'b1000) begin errors++; $display("FAIL mr_gnt3: got %b want 1000", core_gnt); end
        checks++; if (core_rdata !== 12'h111) begin errors++; $display("FAIL mr_rdata0: got %h want 111", core_rdata); end
        commit(); clear_all();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 5; c++) begin
            eval();
            checks++; if (core_gnt !== '0) begin errors++; $display("FAIL idle_gnt[%0d]: got %b want 0", c, core_gnt); end
            checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en[%0d]: got %b want 0", c, mem_wr_en); end
            checks++; if (mem_addr !== '0) begin errors++; $display("FAIL idle_addr[%0d]: got %h want 0", c, mem_addr); end
            checks++; if (core_rvalid !== exp_rvalid) begin errors++; $display("FAIL idle_rvalid[%0d]: got %b want %b", c, core_rvalid, exp_rvalid); end
            checks++; if (core_rdata !== exp_rdata) begin errors++; $display("FAIL idle_rdata[%0d]: got %h want %h", c, core_rdata, exp_rdata); end
            commit();
        end
        for (int i = 0; i < N; i++) set_core(i, 1, 0, 0, 12'h020, 12'h000);
        eval();
        checks++; if (core_gnt !== 4'b0001) begin errors++; $display("FAIL idle_ptr_gnt: got %b want 0001", core_gnt); end
        commit(); clear_all();
        eval(); commit();
    endtask

    task automatic test_random();
        bit pend [N] = '{default: 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    set_core(i, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                             AW'($urandom_range(0, 15)), DW'($urandom));
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0; core_req[i] = 0;
                end
            end
            eval();
            checks++; if (core_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, core_gnt, exp_gnt); end
            checks++; if (core_rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", cyc, core_rvalid, exp_rvalid); end
            checks++; if (core_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, core_rdata, exp_rdata); end
            checks++; if (mem_wr_en !== exp_wr) begin errors++; $display("FAIL rnd_wr_en[%0d]: got %b want %b", cyc, mem_wr_en, exp_wr); end
            if (win >= 0) begin
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", cyc, mem_addr, exp_addr); end
                checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", cyc, mem_wdata, exp_wdata); end
            end
            commit();
            if (win >= 0) begin
                pend[win] = 0; core_req[win] = 0;
                if (exp_lock && $urandom_range(0, 1) == 1) begin
                    pend[win] = 1;
                    set_core(win, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
        end
        clear_all();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one single-port data memory between the `CORE_COUNT` processor cores of the multi-core processor, so each core performs its own loads and stores. Each core issues a request with address, write enable and write data. The arbiter grants at most one core per cycle in round-robin order, drives the memory port, and returns read data to the granted core one cycle later. A lock input lets a core keep ownership across consecutive accesses for read-modify-write sequences.

## Interface
- `CORE_COUNT`, 4, number of requesting cores (2..16)
- `REG_WIDTH`, 12, data word width
- `DATA_MEM_ADDR_WIDTH`, 12, memory address width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `core_req` in CORE_COUNT: bit i is core i's access request
- `core_wr_en` in CORE_COUNT: bit i selects write (1) or read (0) for core i
- `core_lock` in CORE_COUNT: bit i asks to keep the grant after the current access
- `core_addr` in DATA_MEM_ADDR_WIDTH*CORE_COUNT: core i address in slice [i*W +: W]
- `core_wdata` in REG_WIDTH*CORE_COUNT: core i write data, packed the same way
- `core_gnt` out CORE_COUNT: one-hot or zero; core i's access is accepted this cycle
- `core_rvalid` out CORE_COUNT: one-hot or zero; read data valid for core i
- `core_rdata` out REG_WIDTH: read data, shared by all cores and qualified by `core_rvalid`
- `mem_addr` out DATA_MEM_ADDR_WIDTH: memory address
- `mem_wr_en` out 1: memory write strobe
- `mem_wdata` out REG_WIDTH: memory write data
- `mem_rdata` in REG_WIDTH: memory read data, valid one cycle after the address

## Operation
- State consists of:
  - `rr_ptr` (clog2 CORE_COUNT bits): the highest-priority core.
  - `lock_owner` (valid bit plus index).
  - `rd_owner` (valid bit plus index): the pending read return.
- Winner selection:
  - If `lock_owner` is valid and that core's `core_req` is 1, that core wins.
  - Otherwise the winner is the first requesting core scanning from `rr_ptr` upward, wrapping at CORE_COUNT-1 to 0.
  - If no core requests, there is no winner.
- `core_gnt` is combinational from the current `core_req` and state. The winner's addr/wr_en/wdata pass combinationally to `mem_*`.
- With no winner: `mem_wr_en`=0, `mem_addr`/`mem_wdata`=0, `core_gnt`=0.
- On each grant to core k:
  - `rr_ptr` <= (k+1) mod CORE_COUNT, unless k won through the lock; then `rr_ptr` is unchanged.
  - If `core_lock[k]`=1: `lock_owner` <= k, valid.
  - If `core_lock[k]`=0: `lock_owner` is cleared.
- If the lock owner drops `core_req`, `lock_owner` is cleared that cycle and normal round-robin applies in the same cycle.
- On a granted read (wr_en=0) by core k: `rd_owner` <= k, valid. Next cycle `core_rvalid[k]`=1 and `core_rdata`=`mem_rdata`.
- When no read is granted, `rd_owner` valid <= 0.
- A new grant may coincide with a read return: back-to-back reads by the same or different cores return in consecutive cycles.
- Writes produce no `core_rvalid`.
- Requesters hold req/addr/wr_en/wdata stable until sampled `core_gnt`=1. Deasserting req before the grant is legal and withdraws the request.

## Timing
- Grant latency: 0 cycles (same cycle) when the core is the winner. Worst case under full contention: CORE_COUNT-1 cycles, unless a lock is held.
- Read latency: data and `core_rvalid` appear 1 cycle after the grant cycle.
- Throughput: one access per cycle.
- Reset (async assert, registers cleared immediately):
  - `rr_ptr`=0, `lock_owner` invalid, `rd_owner` invalid.
  - All of `core_gnt`, `core_rvalid`, `mem_wr_en` = 0.
  - `core_rdata` = 0 and `mem_addr`/`mem_wdata` = 0 while reset is asserted.
- Reset mid-read: the pending `core_rvalid` is dropped and never issued.
- Release: the first cycle after `rst` deasserts, core 0 has highest priority.

## Structure
- Shared package `core_arb_pkg`: the `clog2`-based index width function and the owner struct (valid, index).
- One sub-module, `rr_priority_picker`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, winner index, any-grant flag.
  - Purely combinational, parameterised by CORE_COUNT.
- The top level holds the lock override, the `rr_ptr`/`lock_owner`/`rd_owner` registers and the memory mux.

## Test plan
- Reset, then core 2 reads addr 0x010 with memory returning 0xABC: `core_gnt`=0100 in cycle 0; `core_rvalid`=0100 and `core_rdata`=0xABC in cycle 1.
- All four cores request continuously (writes to addr i, data 0x100+i): grants 0,1,2,3,0 in consecutive cycles; `mem_addr`/`mem_wdata` match each grant; no `core_rvalid`.
- Core 1 holds req with lock=1 for 3 cycles while cores 0 and 3 request: core 1 is granted 3 times. Core 1 then drops req: core 3 is granted next (`rr_ptr`=2 after the last unlocked grant to core 1), then core 0.
- Back-to-back reads, core 0 then core 1, with memory data 0x111 then 0x222: `core_rvalid` shows 0001 then 0010 in consecutive cycles with the matching data.
- Assert `rst` in the cycle after a granted read: no `core_rvalid`. After release, core 3 and core 0 request together: core 0 is granted first.
- No requests for 5 cycles: `core_gnt`=0, `mem_wr_en`=0, `rr_ptr` unchanged.
